riscv_biu_demux: RTL and testbench
==================================

RISCV_BIU_DEMUX -- requirements
Module: riscv_biu_demux

Interface
REQ-001 SHALL: XLEN, 64, data width.
REQ-002 SHALL: PLEN, 64, address width.
REQ-003 SHALL: TARGETS, 2, number of downstream BIU targets (2..8).
REQ-004 SHALL: TGT_BASE, 0, packed TARGETS x PLEN base addresses; TGT_MASK, 0, packed TARGETS x PLEN region masks.
REQ-005 SHALL: reset rst_ni, asynchronous, active-low; clock clk_i.
REQ-006 SHALL: clk_i  in  1  clock; rst_ni  in  1  async active-low reset.
REQ-007 SHALL: biu_req_i, biu_lock_i, biu_we_i  in  1 each  upstream request, lock, write enable.
REQ-008 SHALL: biu_adri_i  in  PLEN; biu_size_i, biu_type_i, biu_prot_i  in  3 each; biu_d_i  in  XLEN.
REQ-009 SHALL: biu_req_ack_o, biu_d_ack_o, biu_ack_o, biu_err_o  out  1 each; biu_adro_o  out  PLEN; biu_q_o  out  XLEN.
REQ-010 SHALL: tgt_req_o  out  TARGETS  per-target request; tgt_req_ack_i, tgt_d_ack_i, tgt_ack_i, tgt_err_i  in  TARGETS each.
REQ-011 SHALL: tgt_adri_o  out  PLEN, tgt_size_o/tgt_type_o/tgt_prot_o  out  3, tgt_lock_o/tgt_we_o  out  1, tgt_d_o  out  XLEN, all broadcast copies of upstream inputs.
REQ-012 SHALL: tgt_adro_i  in  TARGETS x PLEN; tgt_q_i  in  TARGETS x XLEN.

Function
REQ-013 SHALL: hit[t] = ((biu_adri_i & TGT_MASK[t]) == TGT_BASE[t]); lowest hitting index is dec_tgt; no hit = unmapped.
REQ-014 SHALL: burst count = beats-1: SINGLE/INCR 0, WRAP4/INCR4 3, WRAP8/INCR8 7, WRAP16/INCR16 15.
REQ-015 SHALL: states IDLE, BUSY, ERR; one outstanding transfer or burst at a time.
REQ-016 SHALL: IDLE, mapped: tgt_req_o[dec_tgt]=biu_req_i, others 0; biu_req_ack_o and biu_d_ack_o combinationally from tgt_req_ack_i/tgt_d_ack_i[dec_tgt].
REQ-017 SHALL: IDLE, accept (biu_req_i & biu_req_ack_o): latch active_tgt=dec_tgt, burst_cnt=count, go BUSY.
REQ-018 SHALL: IDLE, unmapped with biu_req_i: all tgt_req_o 0, biu_req_ack_o=1 same cycle, go ERR.
REQ-019 SHALL: BUSY: all tgt_req_o 0, biu_req_ack_o 0; biu_ack_o, biu_err_o, biu_d_ack_o, biu_q_o, biu_adro_o from active_tgt.
REQ-020 SHALL: BUSY, tgt_ack_i[active_tgt]: burst_cnt decrements; when burst_cnt==0 at that ack, go IDLE next cycle.
REQ-021 SHALL: BUSY, tgt_err_i[active_tgt]: forward err, terminate burst, go IDLE regardless of burst_cnt.
REQ-022 SHALL: ERR: biu_err_o=1 exactly one cycle, biu_ack_o 0, biu_q_o 0, then IDLE; remaining burst beats not issued.
REQ-023 SHALL: IDLE: biu_ack_o/biu_err_o 0; biu_q_o/biu_adro_o from active_tgt (don't-care value).
REQ-024 SHALL: simultaneous ack and err from active target: err wins, burst terminates.
REQ-025 SHALL: new request in final-ack cycle not accepted until following IDLE cycle (1-cycle bubble).
REQ-026 SHALL: acks/errs from non-active targets ignored.

Reset
REQ-027 SHALL: on rst_ni low: state IDLE, burst_cnt 0, active_tgt 0; tgt_req_o, biu_ack_o, biu_err_o, biu_req_ack_o, biu_d_ack_o all 0 while in reset.
REQ-028 SHALL: reset mid-burst aborts immediately; no further upstream ack/err after release until new request.

Structure
REQ-029 SHALL: burst type encodings and the IDLE/BUSY/ERR state enum reside in the shared riscv defines package; burst-to-count function shared with the port mux.
REQ-030 SHALL: address decode is one combinational sub-module, riscv_biu_addr_decode, outputs hit vector and dec_tgt.

Verification (TARGETS=2, T0 base 0x0000_0000 mask 0xF000_0000, T1 base 0x1000_0000 mask 0xF000_0000)
REQ-031 SHALL: SINGLE read 0x1000_0040, T1 acks q=0xDEAD_BEEF -> tgt_req_o=2'b10, biu_q_o=0xDEAD_BEEF with biu_ack_o, state IDLE next cycle.
REQ-032 SHALL: INCR4 write 0x0000_0100 -> T0 only, 4 upstream acks, biu_req_ack_o 0 during all 4 beats, IDLE after 4th.
REQ-033 SHALL: SINGLE to 0x2000_0000 -> biu_req_ack_o=1, tgt_req_o=0, biu_err_o=1 exactly next cycle, no ack.
REQ-034 SHALL: WRAP8 to T1, T1 err on beat 3 -> biu_err_o on beat 3, IDLE next cycle, beats 4-8 absent.
REQ-035 SHALL: stray tgt_ack_i[0] during T1 burst -> biu_ack_o unaffected, burst_cnt unchanged.
REQ-036 SHALL: rst_ni low after beat 2 of INCR16 -> all outputs 0, IDLE; new SINGLE after release completes normally.

Source files
------------

// File: rtl/riscv_biu_demux_pkg.sv
// Shared BIU definitions: burst encodings, demux FSM states, burst-length helper.
// Used by the BIU demux and the port mux so both agree on beat counts.
package riscv_biu_demux_pkg;

  localparam logic [2:0] SINGLE = 3'b000;
  localparam logic [2:0] INCR   = 3'b001;
  localparam logic [2:0] WRAP4  = 3'b010;
  localparam logic [2:0] INCR4  = 3'b011;
  localparam logic [2:0] WRAP8  = 3'b100;
  localparam logic [2:0] INCR8  = 3'b101;
  localparam logic [2:0] WRAP16 = 3'b110;
  localparam logic [2:0] INCR16 = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ERR  = 2'd2
  } biu_state_t;

  // Returns beats-1 for a burst type; undefined-length INCR is treated as one beat.
  function automatic logic [3:0] biu_burst_count(input logic [2:0] btype);
    case (btype)
      WRAP4, INCR4:   return 4'd3;
      WRAP8, INCR8:   return 4'd7;
      WRAP16, INCR16: return 4'd15;
      default:        return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/riscv_biu_addr_decode.sv
// Combinational region decode: per-target hit vector and lowest-index hit.
// Zero latency; no flow control.
module riscv_biu_addr_decode #(
  parameter int                       PLEN     = 64,
  parameter int                       TARGETS  = 2,
  parameter logic [TARGETS*PLEN-1:0]  TGT_BASE = '0,
  parameter logic [TARGETS*PLEN-1:0]  TGT_MASK = '0,
  localparam int                      TW       = (TARGETS > 1) ? $clog2(TARGETS) : 1
) (
  input  logic [PLEN-1:0]    i_adr,
  output logic [TARGETS-1:0] o_hit,
  output logic [TW-1:0]      o_dec_tgt
);

  logic [TARGETS-1:0] w_hit;

  always_comb begin
    w_hit = '0;
    for (int t = 0; t < TARGETS; t++) begin
      w_hit[t] = ((i_adr & TGT_MASK[t*PLEN +: PLEN]) == TGT_BASE[t*PLEN +: PLEN]);
    end
  end

  // Scan from the top down so the lowest hitting index is the one left standing.
  always_comb begin
    o_dec_tgt = '0;
    for (int t = TARGETS - 1; t >= 0; t--) begin
      if (w_hit[t]) o_dec_tgt = TW'(t);
    end
  end

  assign o_hit = w_hit;

endmodule

// File: rtl/riscv_biu_demux.sv
// Routes one upstream BIU port to TARGETS downstream BIUs by address region, one transfer/burst at a time.
// Request/req-ack pass through combinationally in IDLE; unmapped requests get a one-cycle error; 1-cycle bubble after a burst.
module riscv_biu_demux
  import riscv_biu_demux_pkg::*;
#(
  parameter int                      XLEN     = 64,
  parameter int                      PLEN     = 64,
  parameter int                      TARGETS  = 2,
  parameter logic [TARGETS*PLEN-1:0] TGT_BASE = '0,
  parameter logic [TARGETS*PLEN-1:0] TGT_MASK = '0
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,

  input  logic                      biu_req_i,
  input  logic                      biu_lock_i,
  input  logic                      biu_we_i,
  input  logic [PLEN-1:0]           biu_adri_i,
  input  logic [2:0]                biu_size_i,
  input  logic [2:0]                biu_type_i,
  input  logic [2:0]                biu_prot_i,
  input  logic [XLEN-1:0]           biu_d_i,
  output logic                      biu_req_ack_o,
  output logic                      biu_d_ack_o,
  output logic                      biu_ack_o,
  output logic                      biu_err_o,
  output logic [PLEN-1:0]           biu_adro_o,
  output logic [XLEN-1:0]           biu_q_o,

  output logic [TARGETS-1:0]        tgt_req_o,
  input  logic [TARGETS-1:0]        tgt_req_ack_i,
  input  logic [TARGETS-1:0]        tgt_d_ack_i,
  input  logic [TARGETS-1:0]        tgt_ack_i,
  input  logic [TARGETS-1:0]        tgt_err_i,
  output logic [PLEN-1:0]           tgt_adri_o,
  output logic [2:0]                tgt_size_o,
  output logic [2:0]                tgt_type_o,
  output logic [2:0]                tgt_prot_o,
  output logic                      tgt_lock_o,
  output logic                      tgt_we_o,
  output logic [XLEN-1:0]           tgt_d_o,
  input  logic [TARGETS*PLEN-1:0]   tgt_adro_i,
  input  logic [TARGETS*XLEN-1:0]   tgt_q_i
);

  localparam int TW = (TARGETS > 1) ? $clog2(TARGETS) : 1;

  biu_state_t         r_state;
  logic [TW-1:0]      r_active_tgt;
  logic [3:0]         r_burst_cnt;

  logic [TARGETS-1:0] w_hit;
  logic [TW-1:0]      w_dec_tgt;
  logic               w_mapped;
  logic               w_accept;
  logic               w_unmapped_req;
  logic               w_act_ack;
  logic               w_act_err;
  logic [XLEN-1:0]    w_q    [TARGETS];
  logic [PLEN-1:0]    w_adro [TARGETS];

  riscv_biu_addr_decode #(
    .PLEN     (PLEN),
    .TARGETS  (TARGETS),
    .TGT_BASE (TGT_BASE),
    .TGT_MASK (TGT_MASK)
  ) u_addr_decode (
    .i_adr     (biu_adri_i),
    .o_hit     (w_hit),
    .o_dec_tgt (w_dec_tgt)
  );

  assign tgt_adri_o = biu_adri_i;
  assign tgt_size_o = biu_size_i;
  assign tgt_type_o = biu_type_i;
  assign tgt_prot_o = biu_prot_i;
  assign tgt_lock_o = biu_lock_i;
  assign tgt_we_o   = biu_we_i;
  assign tgt_d_o    = biu_d_i;

  always_comb begin
    for (int t = 0; t < TARGETS; t++) begin
      w_q[t]    = tgt_q_i[t*XLEN +: XLEN];
      w_adro[t] = tgt_adro_i[t*PLEN +: PLEN];
    end
  end

  assign w_mapped       = |w_hit;
  assign w_accept       = biu_req_i & w_mapped & tgt_req_ack_i[w_dec_tgt];
  assign w_unmapped_req = biu_req_i & ~w_mapped;
  assign w_act_ack      = tgt_ack_i[r_active_tgt];
  assign w_act_err      = tgt_err_i[r_active_tgt];

  always_comb begin
    tgt_req_o     = '0;
    biu_req_ack_o = 1'b0;
    biu_d_ack_o   = 1'b0;
    biu_ack_o     = 1'b0;
    biu_err_o     = 1'b0;
    biu_q_o       = w_q[r_active_tgt];
    biu_adro_o    = w_adro[r_active_tgt];
    case (r_state)
      ST_IDLE: begin
        if (w_mapped) begin
          tgt_req_o[w_dec_tgt] = biu_req_i;
          biu_req_ack_o        = tgt_req_ack_i[w_dec_tgt];
          biu_d_ack_o          = tgt_d_ack_i[w_dec_tgt];
        end else begin
          biu_req_ack_o = biu_req_i;
        end
      end
      ST_BUSY: begin
        // An error from the active target overrides a coincident ack.
        biu_ack_o   = w_act_ack & ~w_act_err;
        biu_err_o   = w_act_err;
        biu_d_ack_o = tgt_d_ack_i[r_active_tgt];
      end
      ST_ERR: begin
        biu_err_o = 1'b1;
        biu_q_o   = '0;
      end
      default: ;
    endcase
    if (!rst_ni) begin
      tgt_req_o     = '0;
      biu_req_ack_o = 1'b0;
      biu_d_ack_o   = 1'b0;
      biu_ack_o     = 1'b0;
      biu_err_o     = 1'b0;
      biu_q_o       = '0;
      biu_adro_o    = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= ST_IDLE;
      r_active_tgt <= '0;
      r_burst_cnt  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_active_tgt <= w_dec_tgt;
            r_burst_cnt  <= biu_burst_count(biu_type_i);
            r_state      <= ST_BUSY;
          end else if (w_unmapped_req) begin
            r_state <= ST_ERR;
          end
        end
        ST_BUSY: begin
          if (w_act_err) begin
            r_burst_cnt <= '0;
            r_state     <= ST_IDLE;
          end else if (w_act_ack) begin
            if (r_burst_cnt == 4'd0) begin
              r_state <= ST_IDLE;
            end else begin
              r_burst_cnt <= r_burst_cnt - 4'd1;
            end
          end
        end
        ST_ERR:  r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_biu_demux.sv
// Scoreboard bench for riscv_biu_demux with two 256 MiB regions at 0x0 and 0x1000_0000.
module tb_riscv_biu_demux;
  import riscv_biu_demux_pkg::*;

  localparam int XLEN    = 64;
  localparam int PLEN    = 64;
  localparam int TARGETS = 2;
  localparam logic [TARGETS*PLEN-1:0] TGT_BASE = {64'h0000_0000_1000_0000, 64'h0000_0000_0000_0000};
  localparam logic [TARGETS*PLEN-1:0] TGT_MASK = {64'h0000_0000_F000_0000, 64'h0000_0000_F000_0000};

  logic                    clk_i = 1'b0;
  logic                    rst_ni;
  logic                    biu_req_i, biu_lock_i, biu_we_i;
  logic [PLEN-1:0]         biu_adri_i;
  logic [2:0]              biu_size_i, biu_type_i, biu_prot_i;
  logic [XLEN-1:0]         biu_d_i;
  logic                    biu_req_ack_o, biu_d_ack_o, biu_ack_o, biu_err_o;
  logic [PLEN-1:0]         biu_adro_o;
  logic [XLEN-1:0]         biu_q_o;
  logic [TARGETS-1:0]      tgt_req_o, tgt_req_ack_i, tgt_d_ack_i, tgt_ack_i, tgt_err_i;
  logic [PLEN-1:0]         tgt_adri_o;
  logic [2:0]              tgt_size_o, tgt_type_o, tgt_prot_o;
  logic                    tgt_lock_o, tgt_we_o;
  logic [XLEN-1:0]         tgt_d_o;
  logic [TARGETS*PLEN-1:0] tgt_adro_i;
  logic [TARGETS*XLEN-1:0] tgt_q_i;

  int vectors     = 0;
  int miscompares = 0;
  logic [XLEN:0] sb[$];   // {err, q} per expected upstream response
  logic [XLEN:0] mon_exp;

  always #5 clk_i = ~clk_i;

  riscv_biu_demux #(
    .XLEN(XLEN), .PLEN(PLEN), .TARGETS(TARGETS), .TGT_BASE(TGT_BASE), .TGT_MASK(TGT_MASK)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .biu_req_i(biu_req_i), .biu_lock_i(biu_lock_i), .biu_we_i(biu_we_i),
    .biu_adri_i(biu_adri_i), .biu_size_i(biu_size_i), .biu_type_i(biu_type_i),
    .biu_prot_i(biu_prot_i), .biu_d_i(biu_d_i),
    .biu_req_ack_o(biu_req_ack_o), .biu_d_ack_o(biu_d_ack_o), .biu_ack_o(biu_ack_o),
    .biu_err_o(biu_err_o), .biu_adro_o(biu_adro_o), .biu_q_o(biu_q_o),
    .tgt_req_o(tgt_req_o), .tgt_req_ack_i(tgt_req_ack_i), .tgt_d_ack_i(tgt_d_ack_i),
    .tgt_ack_i(tgt_ack_i), .tgt_err_i(tgt_err_i), .tgt_adri_o(tgt_adri_o),
    .tgt_size_o(tgt_size_o), .tgt_type_o(tgt_type_o), .tgt_prot_o(tgt_prot_o),
    .tgt_lock_o(tgt_lock_o), .tgt_we_o(tgt_we_o), .tgt_d_o(tgt_d_o),
    .tgt_adro_i(tgt_adro_i), .tgt_q_i(tgt_q_i)
  );

  // Every upstream ack/err must match the oldest queued expectation.
  always @(negedge clk_i) begin
    if (rst_ni === 1'b1 && (biu_ack_o === 1'b1 || biu_err_o === 1'b1)) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_rsp: ack=%b err=%b q=%h, required no response", biu_ack_o, biu_err_o, biu_q_o);
      end else begin
        mon_exp = sb.pop_front();
        if ({biu_err_o, biu_q_o} !== mon_exp) begin
          miscompares++;
          $display("FAIL rsp_data: err=%b q=%h, required err=%b q=%h",
                   biu_err_o, biu_q_o, mon_exp[XLEN], mon_exp[XLEN-1:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic sb_drained(input string name);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL %s_rsp_count: %0d responses missing, required 0", name, sb.size());
    end
    sb.delete();
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; biu_req_i = 1'b1; biu_adri_i = 64'h1000_0040; biu_type_i = SINGLE;
    tgt_req_ack_i = '1; tgt_d_ack_i = '1; tgt_ack_i = '1; tgt_err_i = '1;
    tgt_q_i = {64'h1111_1111, 64'h2222_2222}; tgt_adro_i = {64'h33, 64'h44};
    @(negedge clk_i);
    vectors++;
    if ({tgt_req_o, biu_req_ack_o, biu_d_ack_o, biu_ack_o, biu_err_o} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: req=%b req_ack=%b d_ack=%b ack=%b err=%b, required all 0",
               tgt_req_o, biu_req_ack_o, biu_d_ack_o, biu_ack_o, biu_err_o);
    end
    cyc();
    biu_req_i = 1'b0; tgt_req_ack_i = '0; tgt_d_ack_i = '0; tgt_ack_i = '0; tgt_err_i = '0;
    rst_ni = 1'b1;
    @(negedge clk_i);
    vectors++;
    if ({tgt_req_o, biu_ack_o, biu_err_o} !== 4'b0) begin
      miscompares++;
      $display("FAIL reset_release: req=%b ack=%b err=%b, required 0", tgt_req_o, biu_ack_o, biu_err_o);
    end
  endtask

  task automatic test_single_read();
    cyc();
    biu_req_i = 1'b1; biu_adri_i = 64'h1000_0040; biu_type_i = SINGLE; biu_we_i = 1'b0;
    tgt_req_ack_i = 2'b10; tgt_d_ack_i = 2'b10;
    sb.push_back({1'b0, 64'hDEAD_BEEF});
    @(negedge clk_i);
    vectors++;
    if (tgt_req_o !== 2'b10 || biu_req_ack_o !== 1'b1 || biu_d_ack_o !== 1'b1) begin
      miscompares++;
      $display("FAIL single_req: tgt_req=%b req_ack=%b d_ack=%b, required 10 1 1", tgt_req_o, biu_req_ack_o, biu_d_ack_o);
    end
    cyc();
    biu_req_i = 1'b0; tgt_req_ack_i = '0; tgt_d_ack_i = '0;
    tgt_ack_i = 2'b10; tgt_q_i[XLEN +: XLEN] = 64'hDEAD_BEEF;
    @(negedge clk_i);
    vectors++;
    if (biu_ack_o !== 1'b1) begin
      miscompares++;
      $display("FAIL single_ack: ack=%b, required 1", biu_ack_o);
    end
    cyc();
    tgt_ack_i = '0; biu_req_i = 1'b1;
    @(negedge clk_i);
    vectors++;
    if (tgt_req_o !== 2'b10) begin
      miscompares++;
      $display("FAIL single_idle_after: tgt_req=%b, required 10", tgt_req_o);
    end
    cyc();
    biu_req_i = 1'b0;
    sb_drained("single");
  endtask

  task automatic test_incr4_write();
    cyc();
    biu_req_i = 1'b1; biu_adri_i = 64'h0000_0100; biu_type_i = INCR4; biu_we_i = 1'b1;
    biu_d_i = 64'h0123_4567_89AB_CDEF; tgt_req_ack_i = 2'b01;
    for (int b = 0; b < 4; b++) sb.push_back({1'b0, 64'hA000 + 64'(b)});
    @(negedge clk_i);
    vectors++;
    if (tgt_req_o !== 2'b01 || biu_req_ack_o !== 1'b1 || tgt_we_o !== 1'b1 ||
        tgt_adri_o !== 64'h0000_0100 || tgt_d_o !== 64'h0123_4567_89AB_CDEF) begin
      miscompares++;
      $display("FAIL incr4_req: tgt_req=%b req_ack=%b we=%b adr=%h d=%h, required 01 1 1 100 0123456789abcdef",
               tgt_req_o, biu_req_ack_o, tgt_we_o, tgt_adri_o, tgt_d_o);
    end
    for (int b = 0; b < 4; b++) begin
      cyc();
      tgt_ack_i = 2'b01; tgt_q_i[0 +: XLEN] = 64'hA000 + 64'(b);
      @(negedge clk_i);
      vectors++;
      if (biu_req_ack_o !== 1'b0 || tgt_req_o !== 2'b00 || biu_ack_o !== 1'b1) begin
        miscompares++;
        $display("FAIL incr4_beat%0d: req_ack=%b tgt_req=%b ack=%b, required 0 00 1", b, biu_req_ack_o, tgt_req_o, biu_ack_o);
      end
    end
    cyc();
    tgt_ack_i = '0; tgt_req_ack_i = '0;
    @(negedge clk_i);
    vectors++;
    if (tgt_req_o !== 2'b01) begin
      miscompares++;
      $display("FAIL incr4_idle_after: tgt_req=%b, required 01", tgt_req_o);
    end
    cyc();
    biu_req_i = 1'b0; biu_we_i = 1'b0;
    sb_drained("incr4");
  endtask

  task automatic test_unmapped();
    cyc();
    biu_req_i = 1'b1; biu_adri_i = 64'h2000_0000; biu_type_i = SINGLE; tgt_req_ack_i = '1;
    sb.push_back({1'b1, 64'h0});
    @(negedge clk_i);
    vectors++;
    if (biu_req_ack_o !== 1'b1 || tgt_req_o !== 2'b00 || biu_err_o !== 1'b0) begin
      miscompares++;
      $display("FAIL unmapped_req: req_ack=%b tgt_req=%b err=%b, required 1 00 0", biu_req_ack_o, tgt_req_o, biu_err_o);
    end
    cyc();
    biu_req_i = 1'b0; tgt_req_ack_i = '0;
    @(negedge clk_i);
    vectors++;
    if (biu_err_o !== 1'b1 || biu_ack_o !== 1'b0) begin
      miscompares++;
      $display("FAIL unmapped_err: err=%b ack=%b, required 1 0", biu_err_o, biu_ack_o);
    end
    cyc();
    @(negedge clk_i);
    vectors++;
    if (biu_err_o !== 1'b0) begin
      miscompares++;
      $display("FAIL unmapped_err_len: err=%b, required 0", biu_err_o);
    end
    sb_drained("unmapped");
  endtask

  task automatic test_wrap8_err();
    cyc();
    biu_req_i = 1'b1; biu_adri_i = 64'h1000_0200; biu_type_i = WRAP8; tgt_req_ack_i = 2'b10;
    sb.push_back({1'b0, 64'hB000});
    sb.push_back({1'b0, 64'hB001});
    sb.push_back({1'b1, 64'hB002});
    cyc();
    biu_req_i = 1'b0; tgt_req_ack_i = '0;
    // Third beat carries ack and err together; the error must win.
    for (int b = 0; b < 3; b++) begin
      tgt_ack_i = 2'b10; tgt_err_i = (b == 2) ? 2'b10 : 2'b00;
      tgt_q_i[XLEN +: XLEN] = 64'hB000 + 64'(b);
      @(negedge clk_i);
      vectors++;
      if (biu_err_o !== (b == 2)) begin
        miscompares++;
        $display("FAIL wrap8_beat%0d_err: err=%b, required %b", b, biu_err_o, (b == 2));
      end
      cyc();
    end
    tgt_err_i = '0;
    for (int b = 3; b < 5; b++) begin
      @(negedge clk_i);
      vectors++;
      if (biu_ack_o !== 1'b0) begin
        miscompares++;
        $display("FAIL wrap8_beat%0d_absent: ack=%b, required 0", b, biu_ack_o);
      end
      cyc();
    end
    tgt_ack_i = '0; biu_req_i = 1'b1;
    @(negedge clk_i);
    vectors++;
    if (tgt_req_o !== 2'b10) begin
      miscompares++;
      $display("FAIL wrap8_idle_after: tgt_req=%b, required 10", tgt_req_o);
    end
    cyc();
    biu_req_i = 1'b0;
    sb_drained("wrap8");
  endtask

  task automatic test_stray_ack();
    cyc();
    biu_req_i = 1'b1; biu_adri_i = 64'h1000_0300; biu_type_i = INCR4; tgt_req_ack_i = 2'b10;
    for (int b = 0; b < 4; b++) sb.push_back({1'b0, 64'hC000 + 64'(b)});
    cyc();
    biu_req_i = 1'b0; tgt_req_ack_i = '0;
    for (int c = 0, b = 0; c < 5; c++) begin
      if (c == 1) begin
        tgt_ack_i = 2'b01; tgt_err_i = 2'b01;
      end else begin
        tgt_ack_i = 2'b10; tgt_err_i = 2'b00;
        tgt_q_i[XLEN +: XLEN] = 64'hC000 + 64'(b);
        b++;
      end
      @(negedge clk_i);
      vectors++;
      if (biu_ack_o !== (c != 1) || biu_err_o !== 1'b0) begin
        miscompares++;
        $display("FAIL stray_cycle%0d: ack=%b err=%b, required %b 0", c, biu_ack_o, biu_err_o, (c != 1));
      end
      cyc();
    end
    tgt_ack_i = '0; tgt_err_i = '0; biu_req_i = 1'b1;
    @(negedge clk_i);
    vectors++;
    if (tgt_req_o !== 2'b10) begin
      miscompares++;
      $display("FAIL stray_idle_after: tgt_req=%b, required 10", tgt_req_o);
    end
    cyc();
    biu_req_i = 1'b0;
    sb_drained("stray");
  endtask

  task automatic test_reset_mid_burst();
    cyc();
    biu_req_i = 1'b1; biu_adri_i = 64'h0000_0400; biu_type_i = INCR16; tgt_req_ack_i = 2'b01;
    sb.push_back({1'b0, 64'hD000});
    sb.push_back({1'b0, 64'hD001});
    cyc();
    biu_req_i = 1'b0; tgt_req_ack_i = '0;
    for (int b = 0; b < 2; b++) begin
      tgt_ack_i = 2'b01; tgt_q_i[0 +: XLEN] = 64'hD000 + 64'(b);
      cyc();
    end
    rst_ni = 1'b0; biu_req_i = 1'b1; tgt_req_ack_i = '1; tgt_d_ack_i = '1;
    @(negedge clk_i);
    vectors++;
    if ({tgt_req_o, biu_req_ack_o, biu_d_ack_o, biu_ack_o, biu_err_o} !== 6'b0 ||
        biu_q_o !== '0 || biu_adro_o !== '0) begin
      miscompares++;
      $display("FAIL rst_mid_outputs: req=%b req_ack=%b d_ack=%b ack=%b err=%b q=%h adro=%h, required all 0",
               tgt_req_o, biu_req_ack_o, biu_d_ack_o, biu_ack_o, biu_err_o, biu_q_o, biu_adro_o);
    end
    cyc();
    rst_ni = 1'b1; biu_req_i = 1'b0; tgt_req_ack_i = '0; tgt_d_ack_i = '0;
    @(negedge clk_i);
    vectors++;
    if (biu_ack_o !== 1'b0 || biu_err_o !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_no_rsp: ack=%b err=%b, required 0 0", biu_ack_o, biu_err_o);
    end
    sb_drained("rst_mid_pre");
    cyc();
    tgt_ack_i = '0;
    biu_req_i = 1'b1; biu_adri_i = 64'h0000_0010; biu_type_i = SINGLE; tgt_req_ack_i = 2'b01;
    sb.push_back({1'b0, 64'hE000});
    @(negedge clk_i);
    vectors++;
    if (tgt_req_o !== 2'b01 || biu_req_ack_o !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid_new_req: tgt_req=%b req_ack=%b, required 01 1", tgt_req_o, biu_req_ack_o);
    end
    cyc();
    biu_req_i = 1'b0; tgt_req_ack_i = '0; tgt_ack_i = 2'b01; tgt_q_i[0 +: XLEN] = 64'hE000;
    cyc();
    tgt_ack_i = '0;
    sb_drained("rst_mid_post");
  endtask

  task automatic test_back_to_back();
    cyc();
    biu_req_i = 1'b1; biu_adri_i = 64'h0000_0020; biu_type_i = SINGLE; tgt_req_ack_i = 2'b01;
    sb.push_back({1'b0, 64'hF000});
    cyc();
    biu_adri_i = 64'h1000_0020; tgt_req_ack_i = '1;
    tgt_ack_i = 2'b01; tgt_q_i[0 +: XLEN] = 64'hF000;
    @(negedge clk_i);
    vectors++;
    if (biu_req_ack_o !== 1'b0 || tgt_req_o !== 2'b00) begin
      miscompares++;
      $display("FAIL b2b_bubble: req_ack=%b tgt_req=%b, required 0 00", biu_req_ack_o, tgt_req_o);
    end
    cyc();
    tgt_ack_i = '0;
    sb.push_back({1'b0, 64'hF001});
    @(negedge clk_i);
    vectors++;
    if (tgt_req_o !== 2'b10 || biu_req_ack_o !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_second_req: tgt_req=%b req_ack=%b, required 10 1", tgt_req_o, biu_req_ack_o);
    end
    cyc();
    biu_req_i = 1'b0; tgt_req_ack_i = '0; tgt_ack_i = 2'b10; tgt_q_i[XLEN +: XLEN] = 64'hF001;
    cyc();
    tgt_ack_i = '0;
    sb_drained("b2b");
  endtask

  initial begin
    rst_ni = 1'b0; biu_req_i = 1'b0; biu_lock_i = 1'b0; biu_we_i = 1'b0;
    biu_adri_i = '0; biu_size_i = 3'b011; biu_type_i = SINGLE; biu_prot_i = 3'b000; biu_d_i = '0;
    tgt_req_ack_i = '0; tgt_d_ack_i = '0; tgt_ack_i = '0; tgt_err_i = '0;
    tgt_adro_i = '0; tgt_q_i = '0;
    test_reset();
    test_single_read();
    test_incr4_write();
    test_unmapped();
    test_wrap8_err();
    test_stray_ack();
    test_reset_mid_burst();
    test_back_to_back();
    cyc();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
